// File: rtl/fic_ccc_lock_reset_gen.sv
// Fabric reset generator. It synchronises the FCCC PLL lock into GL1 and
// holds the lock for a qualification window before it releases FAB_RESET_N.
// It re-asserts the reset for a minimum pulse when lock is lost or a soft
// reset is requested, and it counts lock-loss events seen while running.
module fic_ccc_lock_reset_gen #(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned MIN_RST_CYCLES     = 16,
    parameter int unsigned LOSS_CNT_W         = 8
) (
    input  logic                  GL1,
    input  logic                  RESET_N,
    input  logic                  LOCK,
    input  logic                  SOFT_RST_REQ,
    output logic                  FAB_RESET_N,
    output logic                  LOCK_SYNC,
    output logic [1:0]            STATE,
    output logic [LOSS_CNT_W-1:0] LOCK_LOST_CNT
);

    localparam int unsigned QUAL_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int unsigned HOLD_W = (MIN_RST_CYCLES > 1) ? $clog2(MIN_RST_CYCLES) : 1;

    localparam logic [QUAL_W-1:0] QUAL_LAST = QUAL_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_QUAL = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t                  state, state_next;
    logic [SYNC_STAGES-1:0]  sync_ff;
    logic                    lock_s;
    logic [QUAL_W-1:0]       qual_cnt, qual_next;
    logic [HOLD_W-1:0]       hold_cnt, hold_next;
    logic [LOSS_CNT_W-1:0]   loss_cnt, loss_next;
    logic                    fab_rst_n;

    assign lock_s        = sync_ff[SYNC_STAGES-1];
    assign LOCK_SYNC     = lock_s;
    assign STATE         = state;
    assign FAB_RESET_N   = fab_rst_n;
    assign LOCK_LOST_CNT = loss_cnt;

    // The LOCK synchroniser shift register runs from the asynchronous PLL lock into GL1.
    always_ff @(posedge GL1) begin
        if (!RESET_N) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], LOCK};
        end
    end

    // This block computes the next state, the qualification and hold counters, and the loss counter.
    always_comb begin
        state_next = state;
        qual_next  = qual_cnt;
        hold_next  = hold_cnt;
        loss_next  = loss_cnt;
        unique case (state)
            ST_WAIT: begin
                if (lock_s && !SOFT_RST_REQ) begin
                    state_next = ST_QUAL;
                    qual_next  = '0;
                end
            end
            ST_QUAL: begin
                if (!lock_s || SOFT_RST_REQ) begin
                    state_next = ST_WAIT;
                end else if (qual_cnt == QUAL_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    qual_next = qual_cnt + QUAL_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s || SOFT_RST_REQ) begin
                    state_next = ST_HOLD;
                    hold_next  = '0;
                    if (!lock_s && (loss_cnt != '1)) begin
                        loss_next = loss_cnt + LOSS_CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (SOFT_RST_REQ) begin
                    hold_next = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next = ST_WAIT;
                end else begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_next = ST_WAIT;
        endcase
    end

    // This block holds the state, the counters, and the registered fabric reset.
    // FAB_RESET_N is loaded from the next state, so it tracks STATE==RUN on the same edge.
    always_ff @(posedge GL1) begin
        if (!RESET_N) begin
            state     <= ST_WAIT;
            qual_cnt  <= '0;
            hold_cnt  <= '0;
            loss_cnt  <= '0;
            fab_rst_n <= 1'b0;
        end else begin
            state     <= state_next;
            qual_cnt  <= qual_next;
            hold_cnt  <= hold_next;
            loss_cnt  <= loss_next;
            fab_rst_n <= (state_next == ST_RUN);
        end
    end

endmodule

// File: tb/tb_fic_ccc_lock_reset_gen.sv
// Scoreboard bench for fic_ccc_lock_reset_gen. A countdown-based reference
// model predicts outputs per GL1 edge, and a monitor compares them. A second
// instance with a 2-bit loss counter exercises saturation on the same stimulus.
module tb_fic_ccc_lock_reset_gen;

    localparam int SYNC = 2;
    localparam int LSC  = 8;
    localparam int MINR = 4;

    localparam int P_WAIT = 0;
    localparam int P_QUAL = 1;
    localparam int P_RUN  = 2;
    localparam int P_HOLD = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock = 1'b0;
    logic       req = 1'b0;
    logic       fab, fab2, ls, ls2;
    logic [1:0] st, st2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int st;
        int fab;
        int ls;
        int cnt;
        int cnt_sat;
    } exp_t;

    exp_t exp_q[$];

    // model state: phase plus cycles remaining in the timed phases
    int pipe[$];
    int m_phase = P_WAIT;
    int m_left  = 0;
    int m_loss  = 0;
    int m_loss2 = 0;

    fic_ccc_lock_reset_gen #(
        .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(LSC), .MIN_RST_CYCLES(MINR), .LOSS_CNT_W(8)
    ) dut (
        .GL1(clk), .RESET_N(rst_n), .LOCK(lock), .SOFT_RST_REQ(req),
        .FAB_RESET_N(fab), .LOCK_SYNC(ls), .STATE(st), .LOCK_LOST_CNT(cnt)
    );

    fic_ccc_lock_reset_gen #(
        .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(LSC), .MIN_RST_CYCLES(MINR), .LOSS_CNT_W(2)
    ) dut_sat (
        .GL1(clk), .RESET_N(rst_n), .LOCK(lock), .SOFT_RST_REQ(req),
        .FAB_RESET_N(fab2), .LOCK_SYNC(ls2), .STATE(st2), .LOCK_LOST_CNT(cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // advance the model by one GL1 edge with the given sampled inputs
    task automatic model_step(input int r, input int l, input int q);
        exp_t e;
        int lsv;
        if (r == 0) begin
            pipe.delete();
            for (int i = 0; i < SYNC; i++) pipe.push_back(0);
            m_phase = P_WAIT;
            m_left  = 0;
            m_loss  = 0;
            m_loss2 = 0;
        end else begin
            lsv = pipe[SYNC-1];
            case (m_phase)
                P_WAIT: if (lsv == 1 && q == 0) begin
                    m_phase = P_QUAL;
                    m_left  = LSC;
                end
                P_QUAL: if (lsv == 0 || q == 1) begin
                    m_phase = P_WAIT;
                end else begin
                    m_left--;
                    if (m_left == 0) m_phase = P_RUN;
                end
                P_RUN: if (lsv == 0 || q == 1) begin
                    m_phase = P_HOLD;
                    m_left  = MINR;
                    if (lsv == 0) begin
                        if (m_loss < 255) m_loss++;
                        if (m_loss2 < 3) m_loss2++;
                    end
                end
                default: if (q == 1) begin
                    m_left = MINR;
                end else begin
                    m_left--;
                    if (m_left == 0) m_phase = P_WAIT;
                end
            endcase
            pipe.push_front(l);
            void'(pipe.pop_back());
        end
        e.st      = m_phase;
        e.fab     = (m_phase == P_RUN) ? 1 : 0;
        e.ls      = pipe[SYNC-1];
        e.cnt     = m_loss;
        e.cnt_sat = m_loss2;
        exp_q.push_back(e);
    endtask

    // Drive the inputs one cycle at a time on the negedge, and queue the
    // expected response for the following edge.
    task automatic cyc(input int n, input int r, input int l, input int q);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = r[0];
            lock  = l[0];
            req   = q[0];
            model_step(r, l, q);
        end
    endtask

    // Monitor: the outputs are valid on every edge. This pops one
    // expectation per edge when one is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("STATE",          int'(st),   e.st);
                check("FAB_RESET_N",    int'(fab),  e.fab);
                check("LOCK_SYNC",      int'(ls),   e.ls);
                check("LOCK_LOST_CNT",  int'(cnt),  e.cnt);
                check("SAT_CNT",        int'(cnt2), e.cnt_sat);
                check("SAT_FAB_RESET_N", int'(fab2), e.fab);
            end
        end
    end

    initial begin
        int lv, runlen, r, q;
        // reset with LOCK high
        cyc(3, 0, 1, 0);
        // power-up qualification, then a short drop during QUAL
        cyc(6, 1, 1, 0);
        cyc(2, 1, 0, 0);
        cyc(14, 1, 1, 0);
        // lock loss in RUN, recovery
        cyc(10, 1, 0, 0);
        cyc(16, 1, 1, 0);
        // soft reset in RUN, second pulse at hold_cnt=2
        cyc(1, 1, 1, 1);
        cyc(2, 1, 1, 0);
        cyc(1, 1, 1, 1);
        cyc(18, 1, 1, 0);
        // lock loss and soft request together at the FSM
        cyc(2, 1, 0, 0);
        cyc(1, 1, 0, 1);
        cyc(8, 1, 0, 0);
        cyc(16, 1, 1, 0);
        // repeated losses to saturate the narrow counter
        for (int k = 0; k < 5; k++) begin
            cyc(8, 1, 0, 0);
            cyc(14, 1, 1, 0);
        end
        // reset while in HOLD
        cyc(4, 1, 0, 0);
        cyc(2, 0, 0, 0);
        // randomized lock runs, soft requests and occasional reset
        lv = 1;
        runlen = 0;
        for (int i = 0; i < 3000; i++) begin
            if (runlen == 0) begin
                lv = 1 - lv;
                runlen = (lv == 1) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 12));
            end
            runlen--;
            q = ($urandom_range(0, 39) == 0) ? 1 : 0;
            r = ($urandom_range(0, 299) == 0) ? 0 : 1;
            cyc(1, r, lv, q);
        end
        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
